// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers with byte strobes.
// Write commits one cycle after the later of AW/W; reads return one cycle after AR.
module axi_lite_reg_slave #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] SPAN        = 32'(4 * NUM_REGS);

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic [31:0]               awaddr_q, awaddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      aw_held_q, aw_held_d;
  logic                      w_held_q, w_held_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [31:0]               rdata_q, rdata_d;

  logic [31:0] wr_off, rd_off;
  logic [7:0]  wr_idx, rd_idx;
  logic        wr_hit, rd_hit;
  logic [31:0] rd_val;
  logic        unused_ok;

  // Below-base addresses wrap to a huge offset, but the explicit >= keeps intent obvious.
  function automatic logic addr_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  assign wr_off = awaddr_q - BASE_ADDR;
  assign rd_off = araddr - BASE_ADDR;
  assign wr_idx = wr_off[9:2];
  assign rd_idx = rd_off[9:2];
  assign wr_hit = addr_hit(awaddr_q);
  assign rd_hit = addr_hit(araddr);
  assign unused_ok = ^{awprot, arprot, wr_off[31:10], wr_off[1:0], rd_off[31:10], rd_off[1:0]};

  assign awready    = !aw_held_q && !bvalid_q;
  assign wready     = !w_held_q && !bvalid_q;
  assign arready    = !rvalid_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rresp      = rresp_q;
  assign rdata      = rdata_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == 8'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;

    if (awvalid && awready) begin
      awaddr_d  = awaddr;
      aw_held_d = 1'b1;
    end
    if (wvalid && wready) begin
      wdata_d  = wdata;
      wstrb_d  = wstrb;
      w_held_d = 1'b1;
    end

    // Both halves present: commit, and block new AW/W until the response drains.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (wr_hit) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_idx == 8'(k)) begin
            wr_pulse_d[k] = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end
      end
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    if (arvalid && arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? rd_val : 32'h0;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      regs_q     <= '0;
      wr_pulse_q <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
